move_sequencer: RTL

- Sequences the PID steering datapath for a single move command: latches a target heading and a square count, then drives error/err_vld, frwrd and moving into PID.
- Sits between the command interpreter, the gyro (heading/heading_rdy) and the IR line sensor (cntrIR).
- Each move runs align-in-place, ramp-up, cruise with line counting, then ramp-down, and signals completion.

---
 rtl/move_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: sequences one move command for the PID steering datapath.
// Each move aligns in place, ramps forward speed up while counting IR lines,
// ramps speed back down, then pulses mv_done.
// Optional build macro FAST_SIM_EN: steeper ramp steps (x4 up, x8 down).
module move_sequencer #(
  parameter logic [9:0]  FRWRD_INC    = 10'h018,
  parameter logic [9:0]  MAX_FRWRD    = 10'h2A0,
  parameter logic [11:0] HDG_TOL      = 12'h02C,
  parameter int          LINES_PER_SQ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mv_vld,
  output logic        mv_rdy,
  input  logic [11:0] mv_hdg,
  input  logic [3:0]  mv_sqrs,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic [11:0] error,
  output logic        err_vld,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        mv_done
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    DECIDE,
    RAMP_UP,
    RAMP_DOWN,
    DONE
  } state_t;

`ifdef FAST_SIM_EN
  localparam logic [10:0] UP_STEP = {1'b0, FRWRD_INC} << 2;
  localparam logic [10:0] DN_STEP = {1'b0, FRWRD_INC} << 3;
`else
  localparam logic [10:0] UP_STEP = {1'b0, FRWRD_INC};
  localparam logic [10:0] DN_STEP = {1'b0, FRWRD_INC} << 1;
`endif

  localparam logic [5:0] LINES_W = 6'(LINES_PER_SQ);

  state_t      state_q, state_d;
  logic [11:0] error_q, error_d;
  logic        err_vld_q, err_vld_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] hdg_q, hdg_d;
  logic [3:0]  sqrs_q, sqrs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ir_q, ir_d;

  logic [11:0] abs_err;
  logic        align_ok;
  logic [10:0] up_sum;
  logic [9:0]  up_val;
  logic [9:0]  dn_val;
  logic        ir_edge;
  logic [5:0]  target;

  // Magnitude of the registered error; -2048 has no positive twin, clamp it
  assign abs_err  = !error_q[11]        ? error_q :
                    (error_q == 12'h800) ? 12'h7FF : (~error_q + 12'd1);
  assign align_ok = err_vld_q && (abs_err < HDG_TOL);

  // Saturating speed arithmetic: 11-bit sum so the ceiling compare cannot wrap
  assign up_sum = {1'b0, frwrd_q} + UP_STEP;
  assign up_val = (up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[9:0];
  assign dn_val = ({1'b0, frwrd_q} > DN_STEP) ? (frwrd_q - DN_STEP[9:0]) : 10'd0;

  assign ir_edge = cntrIR && !ir_q;
  assign target  = {2'b00, sqrs_q} * LINES_W;

  // Next-state, datapath updates and error generation for the move sequence
  always_comb begin
    state_d   = state_q;
    hdg_d     = hdg_q;
    sqrs_d    = sqrs_q;
    cnt_d     = cnt_q;
    frwrd_d   = frwrd_q;
    ir_d      = cntrIR;
    error_d   = error_q;
    err_vld_d = 1'b0;

    if (heading_rdy && (state_q != IDLE)) begin
      error_d   = heading - hdg_q;
      err_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        frwrd_d = 10'd0;
        if (mv_vld) begin
          hdg_d   = mv_hdg;
          sqrs_d  = mv_sqrs;
          cnt_d   = 6'd0;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        frwrd_d = 10'd0;
        if (align_ok) state_d = DECIDE;
      end
      DECIDE: begin
        frwrd_d = 10'd0;
        state_d = (sqrs_q == 4'd0) ? DONE : RAMP_UP;
      end
      RAMP_UP: begin
        if (heading_rdy) frwrd_d = up_val;
        if (ir_edge)     cnt_d   = cnt_q + 6'd1;
        if (cnt_d == target) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (heading_rdy) frwrd_d = dn_val;
        if (frwrd_q == 10'd0) state_d = DONE;
      end
      DONE: begin
        frwrd_d = 10'd0;
        state_d = IDLE;
      end
      default: begin
        frwrd_d = 10'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      error_q   <= 12'd0;
      err_vld_q <= 1'b0;
      frwrd_q   <= 10'd0;
      hdg_q     <= 12'd0;
      sqrs_q    <= 4'd0;
      cnt_q     <= 6'd0;
      ir_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      err_vld_q <= err_vld_d;
      frwrd_q   <= frwrd_d;
      hdg_q     <= hdg_d;
      sqrs_q    <= sqrs_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
    end
  end

  assign error   = error_q;
  assign err_vld = err_vld_q;
  assign frwrd   = frwrd_q;
  assign mv_rdy  = (state_q == IDLE);
  assign mv_done = (state_q == DONE);
  assign moving  = (state_q == ALIGN) || (state_q == DECIDE) ||
                   (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule
